// File: rtl/unidade_load_store_pkg.sv
// Shared types and constants for the load/store unit.
// Funct3 encodings, FSM states and access-size helper.
package pacote_lsu;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    OCIOSO,
    LER_BAIXO,
    LER_ALTO,
    ESC_BAIXO,
    ESC_ALTO,
    RMW_LER,
    RMW_ESC,
    RESPOSTA
  } estado_t;

  function automatic logic [2:0] tamanho(
    input logic [2:0] f3
  );
    logic [2:0] t;
    unique case (f3[1:0])
      2'b00:   t = 3'd1;
      2'b01:   t = 3'd2;
      default: t = 3'd4;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/unidade_load_store_if.sv
// Request/response and data-memory bus of the load/store unit.
// master = execute stage side, slave = the unit itself.
interface unidade_load_store_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_escrita;
  logic [2:0]  req_funct3;
  logic [31:0] req_endereco;
  logic [31:0] req_dados;
  logic        resp_valid;
  logic [31:0] resp_dados;
  logic        resp_erro;
  logic [31:0] mem_endereco;
  logic [31:0] mem_dados_escrita;
  logic        mem_ler;
  logic        mem_escrever;
  logic [31:0] mem_dados_leitura;

  modport master (
    output req_valid, req_escrita, req_funct3,
    output req_endereco, req_dados,
    output mem_dados_leitura,
    input  req_ready, resp_valid, resp_dados,
    input  resp_erro, mem_endereco,
    input  mem_dados_escrita, mem_ler, mem_escrever
  );

  modport slave (
    input  req_valid, req_escrita, req_funct3,
    input  req_endereco, req_dados,
    input  mem_dados_leitura,
    output req_ready, resp_valid, resp_dados,
    output resp_erro, mem_endereco,
    output mem_dados_escrita, mem_ler, mem_escrever
  );

endinterface

// File: rtl/unidade_load_store_extensor.sv
// Load result formatting: byte/halfword select plus
// sign or zero extension.
module extensor_carga
  import pacote_lsu::*;
(
  input  logic [2:0]  funct3,
  input  logic        lane,
  input  logic [15:0] low_reg,
  input  logic [15:0] high_reg,
  output logic [31:0] resp_dados
);

  logic [7:0] byte_sel;

  assign byte_sel = lane ? low_reg[15:8]
                         : low_reg[7:0];

  always_comb begin
    resp_dados = '0;
    case (funct3)
      F3_LB:  resp_dados = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: resp_dados = {24'h0, byte_sel};
      F3_LH:  resp_dados = {{16{low_reg[15]}}, low_reg};
      F3_LHU: resp_dados = {16'h0, low_reg};
      F3_LW:  resp_dados = {high_reg, low_reg};
      default: resp_dados = '0;
    endcase
  end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit: splits each request into halfword
// accesses to memoria_dados; byte stores use read-modify-write.
module unidade_load_store
  import pacote_lsu::*;
#(
  parameter int unsigned TAM_MEMORIA = 1024
) (
  input logic                  clk,
  input logic                  reset,
  unidade_load_store_if.slave  bus
);

  estado_t     estado_q, estado_d;
  logic        escrita_q, escrita_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] end_q, end_d;
  logic        lane_q, lane_d;
  logic [31:0] dados_q, dados_d;
  logic [15:0] low_q, low_d;
  logic [15:0] high_q, high_d;
  logic        erro_q, erro_d;

  logic [2:0]  tam;
  logic [32:0] ultimo;
  logic        fora;
  logic        ilegal;
  logic        desalinhado;
  logic        erro_req;
  logic        eh_byte;
  logic [31:0] ext_dados;
  logic [15:0] merge;
  logic        unused_leitura;

  // Only the low halfword of the memory read port is meaningful.
  assign unused_leitura = ^bus.mem_dados_leitura[31:16];

  assign tam    = tamanho(bus.req_funct3);
  assign ultimo = {1'b0, bus.req_endereco}
                + {30'h0, tam} - 33'd1;
  assign fora   = ultimo >= 33'(TAM_MEMORIA);

  always_comb begin
    ilegal = 1'b0;
    if (bus.req_escrita)
      ilegal = bus.req_funct3 >= 3'd3;
    else
      ilegal = (bus.req_funct3 == 3'd3)
            || (bus.req_funct3 == 3'd6)
            || (bus.req_funct3 == 3'd7);
  end

  assign desalinhado =
      ((bus.req_funct3[1:0] == 2'b01)
        && bus.req_endereco[0])
   || ((bus.req_funct3[1:0] == 2'b10)
        && (bus.req_endereco[1:0] != 2'b00));

  assign erro_req = ilegal || desalinhado || fora;
  assign eh_byte  = bus.req_funct3[1:0] == 2'b00;

  always_comb begin
    estado_d  = estado_q;
    escrita_d = escrita_q;
    funct3_d  = funct3_q;
    end_d     = end_q;
    lane_d    = lane_q;
    dados_d   = dados_q;
    low_d     = low_q;
    high_d    = high_q;
    erro_d    = erro_q;
    unique case (estado_q)
      OCIOSO: begin
        if (bus.req_valid) begin
          escrita_d = bus.req_escrita;
          funct3_d  = bus.req_funct3;
          lane_d    = bus.req_endereco[0];
          dados_d   = bus.req_dados;
          erro_d    = erro_req;
          end_d     = eh_byte
                    ? {bus.req_endereco[31:1], 1'b0}
                    : bus.req_endereco;
          if (erro_req)
            estado_d = RESPOSTA;
          else if (bus.req_escrita && eh_byte)
            estado_d = RMW_LER;
          else if (bus.req_escrita)
            estado_d = ESC_BAIXO;
          else
            estado_d = LER_BAIXO;
        end
      end
      LER_BAIXO: begin
        low_d    = bus.mem_dados_leitura[15:0];
        estado_d = (funct3_q[1:0] == 2'b10)
                 ? LER_ALTO : RESPOSTA;
      end
      LER_ALTO: begin
        high_d   = bus.mem_dados_leitura[15:0];
        estado_d = RESPOSTA;
      end
      ESC_BAIXO: begin
        estado_d = (funct3_q[1:0] == 2'b10)
                 ? ESC_ALTO : RESPOSTA;
      end
      ESC_ALTO: estado_d = RESPOSTA;
      RMW_LER: begin
        low_d    = bus.mem_dados_leitura[15:0];
        estado_d = RMW_ESC;
      end
      RMW_ESC:  estado_d = RESPOSTA;
      RESPOSTA: estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      escrita_q <= 1'b0;
      funct3_q  <= '0;
      end_q     <= '0;
      lane_q    <= 1'b0;
      dados_q   <= '0;
      low_q     <= '0;
      high_q    <= '0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      escrita_q <= escrita_d;
      funct3_q  <= funct3_d;
      end_q     <= end_d;
      lane_q    <= lane_d;
      dados_q   <= dados_d;
      low_q     <= low_d;
      high_q    <= high_d;
      erro_q    <= erro_d;
    end
  end

  assign merge = lane_q
               ? {dados_q[7:0], low_q[7:0]}
               : {low_q[15:8], dados_q[7:0]};

  always_comb begin
    bus.mem_endereco      = '0;
    bus.mem_dados_escrita = '0;
    bus.mem_ler           = 1'b0;
    bus.mem_escrever      = 1'b0;
    unique case (estado_q)
      LER_BAIXO, RMW_LER: begin
        bus.mem_ler      = 1'b1;
        bus.mem_endereco = end_q;
      end
      LER_ALTO: begin
        bus.mem_ler      = 1'b1;
        bus.mem_endereco = end_q + 32'd2;
      end
      ESC_BAIXO: begin
        bus.mem_escrever      = 1'b1;
        bus.mem_endereco      = end_q;
        bus.mem_dados_escrita = {16'h0, dados_q[15:0]};
      end
      ESC_ALTO: begin
        bus.mem_escrever      = 1'b1;
        bus.mem_endereco      = end_q + 32'd2;
        bus.mem_dados_escrita = {16'h0, dados_q[31:16]};
      end
      RMW_ESC: begin
        bus.mem_escrever      = 1'b1;
        bus.mem_endereco      = end_q;
        bus.mem_dados_escrita = {16'h0, merge};
      end
      default: ;
    endcase
  end

  extensor_carga u_ext (
    .funct3     (funct3_q),
    .lane       (lane_q),
    .low_reg    (low_q),
    .high_reg   (high_q),
    .resp_dados (ext_dados)
  );

  assign bus.req_ready  = estado_q == OCIOSO;
  assign bus.resp_valid = estado_q == RESPOSTA;
  assign bus.resp_erro  = (estado_q == RESPOSTA) && erro_q;
  assign bus.resp_dados =
      ((estado_q == RESPOSTA) && !erro_q && !escrita_q)
      ? ext_dados : '0;

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a byte-array
// model of memoria_dados.
module tb_unidade_load_store;

  logic clk;
  logic reset;

  unidade_load_store_if bus ();

  unidade_load_store #(.TAM_MEMORIA(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  logic [9:0] ra;

  assign ra = bus.mem_endereco[9:0];
  assign bus.mem_dados_leitura =
      {16'h0, mem[ra + 10'd1], mem[ra]};

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
  end

  always @(posedge clk) begin
    if (bus.mem_escrever) begin
      mem[ra]         <= bus.mem_dados_escrita[7:0];
      mem[ra + 10'd1] <= bus.mem_dados_escrita[15:8];
    end
  end

  int n_checks;
  int n_errors;

  int          lat_o;
  logic [31:0] rd_o;
  logic        er_o;
  int          nwr_o;
  int          nrd_o;
  logic [31:0] wra_o;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic do_req(
    input logic        w,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] d
  );
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_escrita  = w;
    bus.req_funct3   = f3;
    bus.req_endereco = a;
    bus.req_dados    = d;
    check("ready_antes", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat_o = 0; rd_o = '0; er_o = 1'b0;
    nwr_o = 0; nrd_o = 0; wra_o = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.mem_ler && bus.mem_escrever)
        check("ler_e_escrever", 32'd1, 32'd0);
      if (bus.mem_escrever) begin
        nwr_o++;
        wra_o = bus.mem_endereco;
      end
      if (bus.mem_ler) nrd_o++;
      if (bus.resp_valid) begin
        lat_o = k;
        rd_o  = bus.resp_dados;
        er_o  = bus.resp_erro;
        break;
      end
    end
    if (lat_o == 0)
      check("timeout_resp", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      check("pulso_unico", 32'(bus.resp_valid), 32'd0);
    end
  endtask

  task automatic expect_req(
    input string       tag,
    input logic        w,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] d,
    input int          exp_lat,
    input logic [31:0] exp_dados,
    input logic        exp_erro
  );
    do_req(w, f3, a, d);
    check({tag, "_lat"}, 32'(lat_o), 32'(exp_lat));
    check({tag, "_dados"}, rd_o, exp_dados);
    check({tag, "_erro"}, 32'(er_o), 32'(exp_erro));
    if (exp_erro)
      check({tag, "_strobes"},
            32'(nwr_o + nrd_o), 32'd0);
  endtask

  int          acc [3];
  int          rsp [3];
  logic [31:0] rdat [3];
  logic [31:0] addrs [3];
  logic [31:0] exps [3];
  int          ia;
  int          ir;
  int          nresp;

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.req_valid    = 1'b0;
    bus.req_escrita  = 1'b0;
    bus.req_funct3   = '0;
    bus.req_endereco = '0;
    bus.req_dados    = '0;
    reset = 1'b1;
    #12;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_dados", bus.resp_dados, 32'd0);
    check("rst_erro", 32'(bus.resp_erro), 32'd0);
    check("rst_ler", 32'(bus.mem_ler), 32'd0);
    check("rst_esc", 32'(bus.mem_escrever), 32'd0);
    check("rst_end", bus.mem_endereco, 32'd0);
    check("rst_wdata", bus.mem_dados_escrita, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    expect_req("sw10", 1, 3'd2, 32'h10,
               32'hDEADBEEF, 3, 32'h0, 0);
    check("sw10_nwr", 32'(nwr_o), 32'd2);
    check("mem10", 32'(mem[10'h10]), 32'hEF);
    check("mem11", 32'(mem[10'h11]), 32'hBE);
    check("mem12", 32'(mem[10'h12]), 32'hAD);
    check("mem13", 32'(mem[10'h13]), 32'hDE);
    expect_req("lw10", 0, 3'd2, 32'h10, 0,
               3, 32'hDEADBEEF, 0);
    expect_req("lb13", 0, 3'd0, 32'h13, 0,
               2, 32'hFFFFFFDE, 0);
    expect_req("lbu13", 0, 3'd4, 32'h13, 0,
               2, 32'h000000DE, 0);
    expect_req("lh12", 0, 3'd1, 32'h12, 0,
               2, 32'hFFFFDEAD, 0);
    expect_req("lhu10", 0, 3'd5, 32'h10, 0,
               2, 32'h0000BEEF, 0);

    expect_req("sb11", 1, 3'd0, 32'h11, 32'h55,
               3, 32'h0, 0);
    check("sb11_nwr", 32'(nwr_o), 32'd1);
    check("sb11_wra", wra_o, 32'h10);
    expect_req("lw10_rmw", 0, 3'd2, 32'h10, 0,
               3, 32'hDEAD55EF, 0);

    expect_req("err_lh21", 0, 3'd1, 32'h21, 0,
               1, 32'h0, 1);
    expect_req("err_sw22", 1, 3'd2, 32'h22,
               32'h12345678, 1, 32'h0, 1);
    expect_req("err_lw3fe", 0, 3'd2, 32'h3FE, 0,
               1, 32'h0, 1);
    expect_req("err_f3", 0, 3'd3, 32'h0, 0,
               1, 32'h0, 1);

    expect_req("sw3fc", 1, 3'd2, 32'h3FC,
               32'h01020304, 3, 32'h0, 0);
    expect_req("lw3fc", 0, 3'd2, 32'h3FC, 0,
               3, 32'h01020304, 0);

    // Reset lands while the upper half of sw @0x40 is on the bus.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_escrita  = 1'b1;
    bus.req_funct3   = 3'd2;
    bus.req_endereco = 32'h40;
    bus.req_dados    = 32'hAABBCCDD;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmid_end_alto", bus.mem_endereco, 32'h42);
    reset = 1'b1;
    #1;
    check("rmid_ready", 32'(bus.req_ready), 32'd1);
    check("rmid_valid", 32'(bus.resp_valid), 32'd0);
    check("rmid_esc", 32'(bus.mem_escrever), 32'd0);
    check("rmid_ler", 32'(bus.mem_ler), 32'd0);
    check("rmid_end", bus.mem_endereco, 32'd0);
    check("rmid_wdata", bus.mem_dados_escrita, 32'd0);
    check("rmid_dados", bus.resp_dados, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nresp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    check("rmid_noresp", 32'(nresp), 32'd0);
    check("rmid_ready_pos", 32'(bus.req_ready), 32'd1);
    check("rmid_mem40", 32'(mem[10'h40]), 32'hDD);
    check("rmid_mem42", 32'(mem[10'h42]), 32'h00);
    check("rmid_mem43", 32'(mem[10'h43]), 32'h00);

    addrs[0] = 32'h10;  exps[0] = 32'h000055EF;
    addrs[1] = 32'h12;  exps[1] = 32'hFFFFDEAD;
    addrs[2] = 32'h3FC; exps[2] = 32'h00000304;
    ia = 0;
    ir = 0;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b1;
    bus.req_escrita  = 1'b0;
    bus.req_funct3   = 3'd1;
    bus.req_endereco = addrs[0];
    for (int c = 0; c < 30 && ir < 3; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        rsp[ir]  = c;
        rdat[ir] = bus.resp_dados;
        ir++;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc[ia] = c;
        ia++;
        @(posedge clk);
        #1;
        if (ia < 3) bus.req_endereco = addrs[ia];
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_nacc", 32'(ia), 32'd3);
    check("b2b_nresp", 32'(ir), 32'd3);
    if (ia == 3 && ir == 3) begin
      check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
      check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b_lat%0d", i),
              32'(rsp[i] - acc[i]), 32'd2);
        check($sformatf("b2b_dados%0d", i),
              rdat[i], exps[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unidade_load_store.md
Name: unidade_load_store

Overview:
- Load/store unit between the execute stage and `memoria_dados`.
- Accepts one memory request per handshake and decodes RISC-V funct3 (lb, lh, lw, lbu, lhu, sb, sh, sw).
- `memoria_dados` transfers exactly one little-endian halfword per access, so the unit sequences one or two halfword accesses per request.
- It implements byte stores as read-modify-write, sign/zero-extends loads and flags misaligned or out-of-range requests.

Parameters:
- TAM_MEMORIA, 1024, data memory size in bytes; any accessed byte at address >= TAM_MEMORIA is an error.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_escrita  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 of the load/store
- req_endereco  input  32  byte address
- req_dados  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_dados  output  32  extended load result; 0 for stores and errors
- resp_erro  output  1  misaligned, out-of-range or illegal funct3
- mem_endereco  output  32  to memoria_dados.endereco
- mem_dados_escrita  output  32  halfword in [15:0]; [31:16] = 0
- mem_ler  output  1  to memoria_dados.ler_memoria
- mem_escrever  output  1  to memoria_dados.escrever_memoria
- mem_dados_leitura  input  32  from memoria_dados; only [15:0] is used

Behaviour:
- Reset values: state OCIOSO; req_ready=1; resp_valid=0; resp_dados=0; resp_erro=0; mem_ler=0; mem_escrever=0; mem_endereco=0; mem_dados_escrita=0.
- Reset mid-operation aborts immediately. No further write is issued, and a pending response is discarded.
- Handshake:
  - Accept on the rising edge where req_valid && req_ready.
  - Capture write flag, funct3, address and data into registers.
  - req_ready=1 only in OCIOSO.
  - resp_valid is a single-cycle pulse with no backpressure.
- Memory outputs are decoded combinationally from state and registers. Reads are combinational in the memory, so read data is captured on the edge that ends the read state. A write commits on the edge that ends the write state.
- States:
  - OCIOSO: wait for a request.
  - LER_BAIXO: read halfword at A0, capture to low_reg.
  - LER_ALTO: read at A0+2, capture to high_reg.
  - ESC_BAIXO: write data[15:0] at A0.
  - ESC_ALTO: write data[31:16] at A0+2.
  - RMW_LER: read halfword at A&~1.
  - RMW_ESC: write the merged halfword.
  - RESPOSTA: resp_valid=1, then return to OCIOSO.
- Address A0:
  - A0 = A for halfword and word accesses.
  - A0 = A&~1 for byte accesses; the byte lane is A[0].
- Sequences (acceptance edge = cycle 0; resp_valid is high in the listed cycle):
  - lb/lbu/lh/lhu: LER_BAIXO -> RESPOSTA (cycle 2).
  - lw: LER_BAIXO -> LER_ALTO -> RESPOSTA (cycle 3).
  - sh: ESC_BAIXO -> RESPOSTA (cycle 2).
  - sw: ESC_BAIXO -> ESC_ALTO -> RESPOSTA (cycle 3).
  - sb: RMW_LER -> RMW_ESC -> RESPOSTA (cycle 3). The merge replaces byte lane A[0] with data[7:0] and keeps the other byte.
- Load extension:
  - lb sign-extends the byte at lane A[0]; lbu zero-extends it.
  - lh sign-extends the halfword; lhu zero-extends it.
  - lw returns {high_reg, low_reg}.
- Error checks: halfword with A[0]=1; word with A[1:0]!=0; last byte (A+size-1) >= TAM_MEMORIA; illegal funct3 (loads: 3, 6, 7; stores: >=3).
- On error: OCIOSO -> RESPOSTA directly (resp_valid at cycle 1), resp_erro=1, resp_dados=0. No mem_ler or mem_escrever is asserted.
- mem_ler and mem_escrever are never both high. Idle outputs are zero.

Decomposition:
- Package pacote_lsu:
  - funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5, F3_SB=0, F3_SH=1, F3_SW=2.
  - State enum: OCIOSO, LER_BAIXO, LER_ALTO, ESC_BAIXO, ESC_ALTO, RMW_LER, RMW_ESC, RESPOSTA.
- Sub-module extensor_carga: combinational byte/halfword select and sign/zero extension. Inputs: funct3, lane, low_reg, high_reg; output: 32-bit resp_dados.

Test Plan:
- Word round trip: sw 0xDEADBEEF @0x10, then lw @0x10 -> resp_dados=0xDEADBEEF at cycle 3. Memory bytes 0x10..0x13 = EF BE AD DE.
- Loads after the word store at 0x10:
  - lb @0x13 -> 0xFFFFFFDE.
  - lbu @0x13 -> 0x000000DE.
  - lh @0x12 -> 0xFFFFDEAD.
  - lhu @0x10 -> 0x0000BEEF.
- Byte RMW: sb 0x55 @0x11 over the above, then lw @0x10 -> 0xDEAD55EF. Check that mem_escrever was high exactly one cycle, at address 0x10.
- Errors, each -> resp_erro=1 at cycle 1 with no memory strobes:
  - lh @0x21.
  - sw @0x22.
  - lw @0x3FE (crosses TAM_MEMORIA).
  - load with funct3=3.
- Boundary: sw 0x01020304 @0x3FC, then lw @0x3FC -> 0x01020304.
- Reset mid-op: assert reset while in ESC_ALTO of sw @0x40 -> all outputs return to reset values at once, req_ready=1 after release, and no resp_valid pulse.
- Back-to-back: req_valid held high with 3 queued lh requests -> exactly one acceptance per OCIOSO visit, and the 3 responses arrive in order 2 cycles apart from their acceptances.
